mat_scalar_seq: RTL and testbench
=================================

Name: mat_scalar_seq

Overview:
- Sequencer for the matrix-by-scalar operation. Accepts a full packed matrix and an 8-bit signed scalar.
- Feeds one matrix row per cycle to the combinational row-by-scalar multiplier stage, then captures that stage's row product and overflow flag.
- Assembles the result matrix and reports completion to the coprocessor control FSM with a sticky overflow flag.

Parameters:
- ROWS, 5, number of matrix rows; also the number of elements per row.
- ELEM_W, 8, signed element width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- mat_i  input  ROWS*ROWS*ELEM_W (200)  packed source matrix; row 0 in the MSBs [199:160], element 0 of each row in that row's MSBs.
- scalar_i  input  ELEM_W (8)  signed scalar multiplier.
- row_o  output  ROWS*ELEM_W (40)  current row presented to the row multiplier.
- scalar_o  output  ELEM_W (8)  latched scalar presented to the row multiplier.
- mult_rst_o  output  1  drives the row multiplier's reset input; 1 whenever the state is not RUN.
- row_res_i  input  40  row product returned by the row multiplier (combinational from row_o/scalar_o).
- row_ovf_i  input  1  row overflow returned by the row multiplier.
- mat_o  output  200  assembled result matrix, same packing as mat_i.
- ovf_o  output  1  sticky OR of row_ovf_i over all rows of the operation.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle completion pulse.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst=1 at a clock edge, any state, including mid-RUN):
  - state=IDLE, row index=0.
  - Latched matrix and latched scalar cleared to 0.
  - mat_o=0, ovf_o=0, done=0, busy=0, row_o=0, scalar_o=0, mult_rst_o=1.
  - An aborted operation produces no done pulse.
- IDLE:
  - busy=0, mult_rst_o=1.
  - When start=1: latch mat_i and scalar_i, set row index=0, clear ovf_o and mat_o to 0, go to RUN.
  - Otherwise hold: mat_o and ovf_o keep the last result.
- RUN, row index k from 0 to ROWS-1:
  - row_o = latched row k (combinational from the index), scalar_o = latched scalar, mult_rst_o=0.
  - At each edge: write row_res_i into mat_o row k, and ovf_o <= ovf_o | row_ovf_i.
  - If k==ROWS-1, go to DONE; else k<=k+1.
  - No wait states; one row per cycle.
- DONE:
  - done=1 for exactly this cycle, busy=1; mat_o and ovf_o are final.
  - Unconditionally return to IDLE at the next edge.
- Output hold in IDLE and DONE: row_o and scalar_o hold their last driven values. mult_rst_o=1 forces the multiplier outputs to 0, and those values are never captured.
- Latency: start sampled at edge 0 → RUN for edges 1..ROWS → done high in the cycle after edge ROWS. done is visible ROWS+1 cycles after the start edge (6 for ROWS=5).
- start while busy (RUN or DONE) is ignored; it is not queued. The next operation requires start in IDLE, so back-to-back operations are separated by at least one IDLE cycle.
- mat_i and scalar_i may change freely after the start edge; only the latched copies are used.
- Arithmetic is performed entirely by the external row multiplier. This block performs no width changes: it moves 40-bit rows and ORs overflow bits.
- mat_o rows not yet written during RUN read as 0. mat_o is valid only from DONE onward.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 → mat_o=0, ovf_o=0, busy=0, done never asserts, mult_rst_o=1.
- Basic operation: mat_i = all elements 0x03, scalar_i=0x02, start for 1 cycle → busy for 6 cycles, done pulse exactly 6 cycles after the start edge. mat_o = all elements 0x06, ovf_o=0. The bench checks that row_o stepped through rows 0..4 in order.
- Signed values and overflow: row 2 element 0 = 100 (0x64), scalar=2, all other elements 1 → row 2 element 0 result follows the multiplier's defined wrap/saturate value. Other elements = 0x02, ovf_o=1, and ovf_o stays 1 in IDLE until the next start. Also check a negative case: element -3 (0xFD) with scalar 5 → 0xF1.
- Start while busy: start held high continuously from IDLE → first operation completes normally. The next operation begins only from IDLE, done pulses are spaced at least 7 cycles apart, and mat_i changed mid-RUN does not affect mat_o.
- Reset mid-operation: rst=1 during RUN at row index 2 → next cycle IDLE, mat_o=0, ovf_o=0, no done pulse. A subsequent start yields a correct full result.
- Sticky overflow clear: an operation with overflow followed by one without → ovf_o=1 after the first, cleared on the second start edge, and 0 at the second done.

Source files
------------

// File: rtl/mat_scalar_seq.sv
// mat_scalar_seq
//   Sequencer for a matrix-by-scalar operation. Latches a packed ROWSxROWS
//   matrix and a signed scalar on start, presents one row per cycle to an
//   external combinational row-by-scalar multiplier, captures each returned
//   row product into the result matrix and accumulates a sticky overflow flag.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   start          begin a new operation (honoured only in IDLE)
//   mat_i          packed source matrix, row 0 in the MSBs, element 0 of a
//                  row in that row's MSBs
//   scalar_i       signed scalar
//   row_o          row currently presented to the multiplier
//   scalar_o       latched scalar presented to the multiplier
//   mult_rst_o     multiplier reset, high whenever not in RUN
//   row_res_i      row product returned by the multiplier
//   row_ovf_i      row overflow returned by the multiplier
//   mat_o          assembled result matrix, same packing as mat_i
//   ovf_o          sticky OR of row_ovf_i over the operation
//   busy           high in RUN and DONE
//   done           one-cycle completion pulse
module mat_scalar_seq #(
  parameter int ROWS   = 5,
  parameter int ELEM_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS*ROWS*ELEM_W-1:0]   mat_i,
  input  logic [ELEM_W-1:0]             scalar_i,
  output logic [ROWS*ELEM_W-1:0]        row_o,
  output logic [ELEM_W-1:0]             scalar_o,
  output logic                          mult_rst_o,
  input  logic [ROWS*ELEM_W-1:0]        row_res_i,
  input  logic                          row_ovf_i,
  output logic [ROWS*ROWS*ELEM_W-1:0]   mat_o,
  output logic                          ovf_o,
  output logic                          busy,
  output logic                          done
);

  localparam int ROW_W = ROWS * ELEM_W;
  localparam int MAT_W = ROWS * ROW_W;
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [MAT_W-1:0]    mat_reg;
  logic [ELEM_W-1:0]   scalar_reg;
  logic [MAT_W-1:0]    res_reg;
  logic                ovf_reg;

  // Latched matrix viewed as an array of rows, row 0 taken from the MSBs.
  logic [ROW_W-1:0]    src_rows [ROWS];

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
      assign src_rows[gi] = mat_reg[MAT_W-1-gi*ROW_W -: ROW_W];
    end
  endgenerate

  // The index stays on the last row after RUN, so row_o keeps showing the
  // last row driven while IDLE/DONE hold the multiplier in reset.
  assign row_o      = src_rows[idx_reg];
  assign scalar_o   = scalar_reg;
  assign mult_rst_o = (state_reg != RUN);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign mat_o      = res_reg;
  assign ovf_o      = ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      mat_reg    <= '0;
      scalar_reg <= '0;
      res_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mat_reg    <= mat_i;
            scalar_reg <= scalar_i;
            idx_reg    <= '0;
            res_reg    <= '0;
            ovf_reg    <= 1'b0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          for (int r = 0; r < ROWS; r++) begin
            if (idx_reg == IDX_W'(r)) begin
              res_reg[MAT_W-1-r*ROW_W -: ROW_W] <= row_res_i;
            end
          end
          ovf_reg <= ovf_reg | row_ovf_i;
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_scalar_seq.sv
// tb_mat_scalar_seq
//   Directed bench for mat_scalar_seq. A behavioural row-by-scalar multiplier
//   (8-bit signed, wrap-around result, overflow when the true product leaves
//   the signed 8-bit range, outputs forced to 0 while held in reset) closes
//   the loop around the sequencer. Expected matrices are hand-written
//   constants.
module tb_mat_scalar_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [199:0] mat_i;
  logic [7:0]   scalar_i;
  logic [39:0]  row_o;
  logic [7:0]   scalar_o;
  logic         mult_rst_o;
  logic [39:0]  row_res;
  logic         row_ovf;
  logic [199:0] mat_o;
  logic         ovf_o;
  logic         busy;
  logic         done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [39:0] seen [5];
  int          nseen;

  localparam logic [199:0] M_03    = {25{8'h03}};
  localparam logic [199:0] M_06    = {25{8'h06}};
  localparam logic [199:0] M_05    = {25{8'h05}};
  localparam logic [199:0] M_0A    = {25{8'h0A}};
  localparam logic [199:0] M_FD    = {25{8'hFD}};
  localparam logic [199:0] M_F1    = {25{8'hF1}};
  localparam logic [199:0] M_ORDER = {{5{8'h10}}, {5{8'h11}}, {5{8'h12}}, {5{8'h13}}, {5{8'h14}}};
  // row 2 element 0 = 100, everything else 1; x2 -> 200 wraps to 0xC8
  localparam logic [199:0] M_OVF2  = {{10{8'h01}}, 8'h64, {14{8'h01}}};
  localparam logic [199:0] R_OVF2  = {{10{8'h02}}, 8'hC8, {14{8'h02}}};
  // row 0 element 0 = 100 so overflow is flagged on the very first row
  localparam logic [199:0] M_OVF0  = {8'h64, {24{8'h01}}};

  logic [39:0] order_rows [5] = '{40'h1010101010, 40'h1111111111, 40'h1212121212,
                                  40'h1313131313, 40'h1414141414};

  mat_scalar_seq #(.ROWS(5), .ELEM_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mat_i      (mat_i),
    .scalar_i   (scalar_i),
    .row_o      (row_o),
    .scalar_o   (scalar_o),
    .mult_rst_o (mult_rst_o),
    .row_res_i  (row_res),
    .row_ovf_i  (row_ovf),
    .mat_o      (mat_o),
    .ovf_o      (ovf_o),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] mul_row(input logic [39:0] r, input logic [7:0] s);
    logic [39:0] res;
    logic        ovf;
    int          p;
    res = '0;
    ovf = 1'b0;
    for (int e = 0; e < 5; e++) begin
      p = $signed(r[39-8*e -: 8]) * $signed(s);
      res[39-8*e -: 8] = p[7:0];
      if (p > 127 || p < -128) ovf = 1'b1;
    end
    return {ovf, res};
  endfunction

  always_comb begin
    row_res = '0;
    row_ovf = 1'b0;
    if (!mult_rst_o) {row_ovf, row_res} = mul_row(row_o, scalar_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Starts an operation and advances to its DONE cycle (bounded). lat is the
  // cycle number of done, counting the cycle after the start edge as 1.
  task automatic run_op(input logic [199:0] m, input logic [7:0] s,
                        output int lat, output int nbusy);
    mat_i    = m;
    scalar_i = s;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 1;
    nbusy    = 0;
    nseen    = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (!mult_rst_o && nseen < 5) begin
        seen[nseen] = row_o;
        nseen++;
      end
      tick();
      lat++;
    end
    if (busy) nbusy++;
  endtask

  initial begin
    int lat, nbusy, ndone, d1, d2;
    logic [199:0] m1, m2;

    rst = 1'b1; start = 1'b0; mat_i = '0; scalar_i = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_mat_o",   mat_o, '0);
    check("rst_ovf_o",   ovf_o, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_mult_rst", mult_rst_o, 1);
    check("rst_row_o",   row_o, '0);
    check("rst_scalar_o", scalar_o, '0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (done) ndone++; end
    check("idle_no_done", ndone, 0);

    // basic: 3 * 2 = 6 everywhere
    run_op(M_03, 8'h02, lat, nbusy);
    check("basic_latency", lat, 6);
    check("basic_busy_cycles", nbusy, 6);
    check("basic_done", done, 1);
    check("basic_mat_o", mat_o, M_06);
    check("basic_ovf_o", ovf_o, 0);
    check("basic_rows_seen", nseen, 5);
    check("basic_row0", seen[0], 40'h0303030303);
    check("basic_scalar_o", scalar_o, 8'h02);
    tick();
    check("basic_done_pulse", done, 0);
    check("basic_idle_busy", busy, 0);
    check("basic_hold_mat_o", mat_o, M_06);

    // row order: distinct rows, scalar 1 returns the source
    tick();
    run_op(M_ORDER, 8'h01, lat, nbusy);
    for (int r = 0; r < 5; r++) check($sformatf("order_row%0d", r), seen[r], order_rows[r]);
    check("order_mat_o", mat_o, M_ORDER);
    tick();

    // overflow in row 2, sticky through IDLE
    run_op(M_OVF2, 8'h02, lat, nbusy);
    check("ovf_mat_o", mat_o, R_OVF2);
    check("ovf_ovf_o", ovf_o, 1);
    tick(); tick(); tick();
    check("ovf_sticky_idle", ovf_o, 1);
    check("ovf_hold_mat_o", mat_o, R_OVF2);

    // negative case, and sticky overflow cleared by the start edge
    mat_i = M_FD; scalar_i = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_ovf_at_start", ovf_o, 0);
    check("clr_mat_at_start", mat_o, '0);
    lat = 1;
    while (!done && lat < 20) begin tick(); lat++; end
    check("neg_latency", lat, 6);
    check("neg_mat_o", mat_o, M_F1);
    check("neg_ovf_o", ovf_o, 0);
    tick();

    // start held high; mat_i changed mid-RUN
    mat_i = M_03; scalar_i = 8'h02; start = 1'b1;
    d1 = -1; d2 = -1; m1 = '0; m2 = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 2) mat_i = M_05;
      if (done) begin
        if (d1 < 0) begin d1 = c; m1 = mat_o; end
        else if (d2 < 0) begin d2 = c; m2 = mat_o; end
      end
    end
    start = 1'b0;
    check("held_first_done", d1, 6);
    check("held_spacing", d2 - d1, 7);
    check("held_first_mat", m1, M_06);
    check("held_second_mat", m2, M_0A);
    tick(); tick();
    check("held_idle_busy", busy, 0);

    // reset at row index 2
    mat_i = M_OVF0; scalar_i = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort_ovf_before", ovf_o, 1);
    tick();
    check("abort_row2", row_o, 40'h0101010101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_mat_o", mat_o, '0);
    check("abort_ovf_o", ovf_o, 0);
    check("abort_mult_rst", mult_rst_o, 1);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin if (done) ndone++; tick(); end
    check("abort_no_done", ndone, 0);
    run_op(M_ORDER, 8'h01, lat, nbusy);
    check("after_abort_latency", lat, 6);
    check("after_abort_mat_o", mat_o, M_ORDER);
    check("after_abort_ovf_o", ovf_o, 0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
